// File: rtl/interrupt_controller_pkg.sv
// Shared configuration, state encoding and constants for the interrupt controller.
package interrupt_controller_pkg;

  // Number of maskable request lines; line 0 has the highest priority.
  localparam int NUM_IRQ = 8;
  // Vector width; 2**VEC_W must exceed NUM_IRQ so that NMI_CODE fits.
  localparam int VEC_W   = 4;

  // Vector value reported while the non-maskable source is in service.
  localparam logic [VEC_W-1:0]   NMI_CODE = VEC_W'(NUM_IRQ);
  // Mask value after reset: every maskable line blocked.
  localparam logic [NUM_IRQ-1:0] MASK_ALL = {NUM_IRQ{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_INT = 2'd1,
    REQ_NMI = 2'd2,
    SERVICE = 2'd3
  } state_e;

endpackage

// File: rtl/interrupt_controller_if.sv
// Bundle of request, acknowledge and status signals between the controller
// (slave) and the processor/device side (master).
interface interrupt_controller_if;
  import interrupt_controller_pkg::*;

  logic [NUM_IRQ-1:0] irq;
  logic               nmi_req;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_in;
  logic               eoi;
  logic               INA;
  logic               INT;
  logic               NMI;
  logic               INTD;
  logic [VEC_W-1:0]   vector;
  logic [NUM_IRQ-1:0] pending;

  modport master (
    output irq, nmi_req, mask_we, mask_in, eoi, INA,
    input  INT, NMI, INTD, vector, pending
  );

  modport slave (
    input  irq, nmi_req, mask_we, mask_in, eoi, INA,
    output INT, NMI, INTD, vector, pending
  );

endinterface

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports whether any line is eligible and the lowest
// eligible index (0 when nothing is eligible).
module irq_priority_encoder
  import interrupt_controller_pkg::*;
(
  input  logic [NUM_IRQ-1:0] eligible_i,
  output logic               any_o,
  output logic [VEC_W-1:0]   idx_o
);

  // Scan from the top down so the lowest set index is written last and wins.
  always_comb begin
    any_o = |eligible_i;
    idx_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible_i[i]) idx_o = VEC_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Priority interrupt controller: edge-captures device and NMI requests,
// arbitrates by fixed priority, hands the winner to the processor via
// INT/NMI + INA, and tracks the in-service source (one-level NMI nesting).
module interrupt_controller
  import interrupt_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  interrupt_controller_if.slave  bus
);

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, pending_q, mask_q, clr_mask;
  logic               nmi_q, nmi_pend_q, ina_q;
  logic               req_any_q, enc_any;
  logic [VEC_W-1:0]   req_id_q, enc_idx;
  logic [VEC_W-1:0]   vector_q, vector_d, saved_q, saved_d;
  logic               saved_vld_q, saved_vld_d;
  logic               ack_int, ack_nmi;

  wire [NUM_IRQ-1:0] irq_rise = bus.irq & ~irq_q;
  wire               nmi_rise = bus.nmi_req & ~nmi_q;
  wire               ina_rise = bus.INA & ~ina_q;

  irq_priority_encoder u_enc (
    .eligible_i (pending_q & ~mask_q),
    .any_o      (enc_any),
    .idx_o      (enc_idx)
  );

  // One-hot clear of the pending bit being acknowledged.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
      assign clr_mask[gi] = ack_int && (req_id_q == VEC_W'(gi));
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus acknowledge strobes and vector/context updates.
  always_comb begin
    state_d     = state_q;
    vector_d    = vector_q;
    saved_d     = saved_q;
    saved_vld_d = saved_vld_q;
    ack_int     = 1'b0;
    ack_nmi     = 1'b0;
    case (state_q)
      IDLE: begin
        if (nmi_pend_q)     state_d = REQ_NMI;
        else if (req_any_q) state_d = REQ_INT;
      end
      REQ_INT: begin
        if (nmi_pend_q)      state_d = REQ_NMI;
        else if (!req_any_q) state_d = IDLE;
        else if (ina_rise) begin
          ack_int  = 1'b1;
          vector_d = req_id_q;
          state_d  = SERVICE;
        end
      end
      REQ_NMI: begin
        if (ina_rise) begin
          ack_nmi  = 1'b1;
          vector_d = NMI_CODE;
          state_d  = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.eoi) begin
          if (saved_vld_q) begin
            vector_d    = saved_q;
            saved_vld_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (nmi_pend_q && (vector_q != NMI_CODE)) begin
          // Preempt a maskable handler; a nested NMI waits for its own eoi.
          saved_d     = vector_q;
          saved_vld_d = 1'b1;
          state_d     = REQ_NMI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge samples, pending/mask registers, arbitration result and context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q       <= '0;
      nmi_q       <= 1'b0;
      ina_q       <= 1'b0;
      pending_q   <= '0;
      nmi_pend_q  <= 1'b0;
      mask_q      <= MASK_ALL;
      req_any_q   <= 1'b0;
      req_id_q    <= '0;
      vector_q    <= '0;
      saved_q     <= '0;
      saved_vld_q <= 1'b0;
    end else begin
      irq_q       <= bus.irq;
      nmi_q       <= bus.nmi_req;
      ina_q       <= bus.INA;
      // A new edge on a bit being cleared keeps the bit set.
      pending_q   <= (pending_q & ~clr_mask) | irq_rise;
      nmi_pend_q  <= (nmi_pend_q & ~ack_nmi) | nmi_rise;
      if (bus.mask_we) mask_q <= bus.mask_in;
      req_any_q   <= enc_any;
      req_id_q    <= enc_idx;
      vector_q    <= vector_d;
      saved_q     <= saved_d;
      saved_vld_q <= saved_vld_d;
    end
  end

  assign bus.INT     = (state_q == REQ_INT);
  assign bus.NMI     = (state_q == REQ_NMI);
  assign bus.INTD    = (state_q == SERVICE);
  assign bus.vector  = vector_q;
  assign bus.pending = pending_q;

endmodule
